z_c_mask_buffer: RTL and testbench

Z_C_MASK_BUFFER -- requirements
Module: z_c_mask_buffer

---
 rtl/dfdd_pkg.sv | 25 ++
 rtl/dfdd_sync_fifo.sv | 58 +++++
 rtl/z_c_mask_buffer.sv | 127 ++++++++++++
 tb/tb_z_c_mask_buffer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/dfdd_pkg.sv
// Shared constants and masked-value helpers for the depth/confidence datapath.
package dfdd_pkg;

    // Width of the pixel column/row coordinates carried alongside each sample.
    localparam int COORD_WIDTH = 16;

    // Widest floating-point word the helper functions can describe.
    localparam int FP_MAX_WIDTH = 128;

    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB 1, rest 0.
    function automatic logic [FP_MAX_WIDTH-1:0] qnan(input int expWidth, input int fracWidth);
        logic [FP_MAX_WIDTH-1:0] value;
        value = ((FP_MAX_WIDTH'(1) << expWidth) - FP_MAX_WIDTH'(1)) << fracWidth;
        if (fracWidth > 0) begin
            value = value | (FP_MAX_WIDTH'(1) << (fracWidth - 1));
        end
        return value;
    endfunction

    // Positive zero is all bits clear in any IEEE-style format.
    function automatic logic [FP_MAX_WIDTH-1:0] pos_zero();
        return '0;
    endfunction

endpackage

// File: rtl/dfdd_sync_fifo.sv
// Single-clock show-ahead FIFO; head entry is presented on data_o while not empty.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module dfdd_sync_fifo
    import dfdd_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [AW:0]           count_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wrPtr_q;
    logic [AW-1:0]         rdPtr_q;
    logic [AW:0]           count_q;
    logic                  doPush;
    logic                  doPop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign doPop   = pop_i && !empty_o;
    assign doPush  = push_i && (!full_o || doPop);

    // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
            if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
            unique case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; stale contents are hidden behind empty_o.
    always_ff @(posedge clk_i) begin
        if (doPush) mem_q[wrPtr_q] <= data_i;
    end

    assign data_o = empty_o ? '0 : mem_q[rdPtr_q];

endmodule

// File: rtl/z_c_mask_buffer.sv
// Confidence-masks depth samples and buffers them in a show-ahead output FIFO.
// Build option DFDD_Z_MASK_NAN_EN: masked depth becomes quiet NaN instead of +0.
module z_c_mask_buffer
    import dfdd_pkg::*;
#(
    parameter int EXP_WIDTH     = 0,
    parameter int FRAC_WIDTH    = 0,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480,
    parameter int FIFO_DEPTH    = 16,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH,
    localparam int CNT_WIDTH    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] z_i,
    input  logic [FP_WIDTH_REG-1:0] c_i,
    input  logic [COORD_WIDTH-1:0]  col_i,
    input  logic [COORD_WIDTH-1:0]  row_i,
    input  logic                    valid_i,
    input  logic [FP_WIDTH_REG-1:0] threshold_i,
    input  logic                    clear_ovf_i,
    input  logic                    ready_i,
    output logic [FP_WIDTH_REG-1:0] z_o,
    output logic [FP_WIDTH_REG-1:0] c_o,
    output logic [COORD_WIDTH-1:0]  col_o,
    output logic [COORD_WIDTH-1:0]  row_o,
    output logic                    masked_o,
    output logic                    last_o,
    output logic                    valid_o,
    output logic [CNT_WIDTH-1:0]    count_o,
    output logic                    overflow_o,
    output logic [15:0]             frame_cnt_o
);

    localparam int ENTRY_WIDTH = 2 + 2*COORD_WIDTH + 2*FP_WIDTH_REG;

`ifdef DFDD_Z_MASK_NAN_EN
    localparam logic [FP_MAX_WIDTH-1:0] MASKED_FULL = qnan(EXP_WIDTH, FRAC_WIDTH);
`else
    localparam logic [FP_MAX_WIDTH-1:0] MASKED_FULL = pos_zero();
`endif
    localparam logic [FP_WIDTH_REG-1:0] MASKED_Z = MASKED_FULL[FP_WIDTH_REG-1:0];

    logic                   magMasked;
    logic                   lastPixel;
    logic                   s1Valid_d;
    logic                   s1Valid_q;
    logic [ENTRY_WIDTH-1:0] s1Entry_d;
    logic [ENTRY_WIDTH-1:0] s1Entry_q;
    logic [ENTRY_WIDTH-1:0] headEntry;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   popFire;
    logic                   dropFire;
    logic                   overflow_q;
    logic [15:0]            frameCnt_q;
    logic                   unusedSignBits;

    // Threshold sign is meaningless for a magnitude compare.
    assign unusedSignBits = threshold_i[FP_WIDTH_REG-1];

    generate
        if (FP_WIDTH_REG > 1) begin : gMagCompare
            assign magMasked = c_i[FP_WIDTH_REG-2:0] < threshold_i[FP_WIDTH_REG-2:0];
        end else begin : gSignOnly
            assign magMasked = 1'b0;
        end
    endgenerate

    assign lastPixel = (col_i == COORD_WIDTH'(IMAGE_WIDTH - 1)) &&
                       (row_i == COORD_WIDTH'(IMAGE_HEIGHT - 1));

    // Build the stage-1 entry: masked flag, frame-end flag, coordinates, c and substituted z.
    always_comb begin
        s1Valid_d = valid_i;
        s1Entry_d = {magMasked, lastPixel, row_i, col_i, c_i, magMasked ? MASKED_Z : z_i};
    end

    // Stage-1 valid is reset so in-flight beats vanish on reset assertion.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) s1Valid_q <= 1'b0;
        else        s1Valid_q <= s1Valid_d;
    end

    // Stage-1 payload only loads on a beat; it is ignored while s1Valid_q is low.
    always_ff @(posedge clk_i) begin
        if (valid_i) s1Entry_q <= s1Entry_d;
    end

    dfdd_sync_fifo #(
        .DATA_WIDTH(ENTRY_WIDTH),
        .DEPTH     (FIFO_DEPTH)
    ) uFifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (s1Valid_q),
        .pop_i  (popFire),
        .data_i (s1Entry_q),
        .data_o (headEntry),
        .full_o (fifoFull),
        .empty_o(fifoEmpty),
        .count_o(count_o)
    );

    assign valid_o  = !fifoEmpty;
    assign popFire  = valid_o && ready_i;
    assign dropFire = s1Valid_q && fifoFull && !popFire;

    // Sticky drop flag; a fresh drop wins over a simultaneous clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)           overflow_q <= 1'b0;
        else if (dropFire)    overflow_q <= 1'b1;
        else if (clear_ovf_i) overflow_q <= 1'b0;
    end

    // Count frames as their final pixel leaves the buffer; wraps at 16 bits.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                 frameCnt_q <= '0;
        else if (popFire && last_o) frameCnt_q <= frameCnt_q + 16'd1;
    end

    assign {masked_o, last_o, row_o, col_o, c_o, z_o} = headEntry;
    assign overflow_o  = overflow_q;
    assign frame_cnt_o = frameCnt_q;

endmodule

// File: tb/tb_z_c_mask_buffer.sv
// Directed bench for z_c_mask_buffer in fp32 with a 4x2 image and a 4-deep FIFO.
module tb_z_c_mask_buffer;

    localparam logic [31:0] THRESH = 32'h3F00_0000;
    localparam logic [31:0] PASSC  = 32'h3F80_0000;
`ifdef DFDD_Z_MASK_NAN_EN
    localparam logic [31:0] MZ = 32'h7FC0_0000;
`else
    localparam logic [31:0] MZ = 32'h0000_0000;
`endif

    logic        clk;
    logic        rstN;
    logic [31:0] zIn, cIn, threshIn;
    logic [15:0] colIn, rowIn;
    logic        validIn, clearOvf, readyIn;
    logic [31:0] zOut, cOut;
    logic [15:0] colOut, rowOut;
    logic        maskedOut, lastOut, validOut, overflowOut;
    logic [2:0]  countOut;
    logic [15:0] frameCntOut;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] c;
        logic [31:0] z;
        logic        expMasked;
        logic [31:0] expZ;
    } maskVec_t;

    maskVec_t maskVecs[5] = '{
        '{32'h3F80_0000, 32'h4020_0000, 1'b0, 32'h4020_0000},
        '{32'h3E80_0000, 32'h4020_0000, 1'b1, MZ},
        '{32'h3F00_0000, 32'hC0A0_0000, 1'b0, 32'hC0A0_0000},
        '{32'h3EFF_FFFF, 32'h3F80_0000, 1'b1, MZ},
        '{32'h0000_0000, 32'h1234_5678, 1'b1, MZ}
    };

    z_c_mask_buffer #(
        .EXP_WIDTH   (8),
        .FRAC_WIDTH  (23),
        .IMAGE_WIDTH (4),
        .IMAGE_HEIGHT(2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rstN),
        .z_i        (zIn),
        .c_i        (cIn),
        .col_i      (colIn),
        .row_i      (rowIn),
        .valid_i    (validIn),
        .threshold_i(threshIn),
        .clear_ovf_i(clearOvf),
        .ready_i    (readyIn),
        .z_o        (zOut),
        .c_o        (cOut),
        .col_o      (colOut),
        .row_o      (rowOut),
        .masked_o   (maskedOut),
        .last_o     (lastOut),
        .valid_o    (validOut),
        .count_o    (countOut),
        .overflow_o (overflowOut),
        .frame_cnt_o(frameCntOut)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] z, input logic [31:0] c,
                                 input logic [15:0] col, input logic [15:0] row);
        validIn = v;
        zIn     = z;
        cIn     = c;
        colIn   = col;
        rowIn   = row;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed scenario sequence.
    initial begin
        rstN     = 1'b0;
        threshIn = THRESH;
        clearOvf = 1'b0;
        readyIn  = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 16'h0);

        #12;
        checkOutput("rst_valid", 64'(validOut), 64'(0));
        checkOutput("rst_count", 64'(countOut), 64'(0));
        checkOutput("rst_ovf", 64'(overflowOut), 64'(0));
        checkOutput("rst_frame", 64'(frameCntOut), 64'(0));
        checkOutput("rst_z", 64'(zOut), 64'(0));
        rstN = 1'b1;
        tick();

        $display("[TB] mask vectors");
        readyIn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, maskVecs[i].z, maskVecs[i].c, 16'h0, 16'h0);
            tick();
            applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 16'h0);
            checkOutput("lat_early_valid", 64'(validOut), 64'(0));
            tick();
            checkOutput("lat_valid", 64'(validOut), 64'(1));
            checkOutput("mask_z", 64'(zOut), 64'(maskVecs[i].expZ));
            checkOutput("mask_c", 64'(cOut), 64'(maskVecs[i].c));
            checkOutput("mask_flag", 64'(maskedOut), 64'(maskVecs[i].expMasked));
            tick();
            checkOutput("popped_valid", 64'(validOut), 64'(0));
        end

        threshIn = 32'hBF00_0000;
        applyStimulus(1'b1, 32'h4020_0000, 32'h3E80_0000, 16'h0, 16'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 16'h0);
        tick();
        checkOutput("thr_sign_masked", 64'(maskedOut), 64'(1));
        checkOutput("thr_sign_z", 64'(zOut), 64'(MZ));
        tick();
        threshIn = THRESH;

        $display("[TB] overflow");
        readyIn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 32'(i + 1), PASSC, 16'(i), 16'h0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 16'h0);
        tick();
        tick();
        checkOutput("ovf_count", 64'(countOut), 64'(4));
        checkOutput("ovf_flag", 64'(overflowOut), 64'(1));
        checkOutput("ovf_head", 64'(zOut), 64'(1));
        clearOvf = 1'b1;
        tick();
        clearOvf = 1'b0;
        checkOutput("clr_flag", 64'(overflowOut), 64'(0));
        checkOutput("clr_head", 64'(zOut), 64'(1));
        checkOutput("clr_count", 64'(countOut), 64'(4));

        $display("[TB] full boundary");
        applyStimulus(1'b1, 32'd6, PASSC, 16'h0, 16'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 16'h0);
        readyIn = 1'b1;
        tick();
        readyIn = 1'b0;
        checkOutput("full_count", 64'(countOut), 64'(4));
        checkOutput("full_ovf", 64'(overflowOut), 64'(0));
        readyIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("order_z", 64'(zOut), 64'((i < 3) ? (i + 2) : 6));
            tick();
        end
        checkOutput("drain_valid", 64'(validOut), 64'(0));
        checkOutput("drain_count", 64'(countOut), 64'(0));

        $display("[TB] frame end");
        for (int i = 0; i < 17; i++) begin
            if (i < 16) applyStimulus(1'b1, 32'(i), PASSC, 16'(i % 4), 16'((i / 4) % 2));
            else        applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 16'h0);
            tick();
            if (i >= 1) begin
                checkOutput("frame_valid", 64'(validOut), 64'(1));
                checkOutput("frame_col", 64'(colOut), 64'((i - 1) % 4));
                checkOutput("frame_last", 64'(lastOut), 64'(((i - 1) % 8) == 7));
            end
            if (i == 9) checkOutput("frame_mid", 64'(frameCntOut), 64'(1));
        end
        tick();
        checkOutput("frame_cnt", 64'(frameCntOut), 64'(2));
        checkOutput("frame_idle", 64'(validOut), 64'(0));

        $display("[TB] reset mid-stream");
        readyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'hA + 32'(i), PASSC, 16'h0, 16'h0);
            tick();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 16'h0);
        tick();
        tick();
        checkOutput("pre_rst_count", 64'(countOut), 64'(3));
        #3;
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(validOut), 64'(0));
        checkOutput("mid_rst_count", 64'(countOut), 64'(0));
        checkOutput("mid_rst_frame", 64'(frameCntOut), 64'(0));
        checkOutput("mid_rst_z", 64'(zOut), 64'(0));
        applyStimulus(1'b1, 32'h55, PASSC, 16'h0, 16'h0);
        #2;
        rstN = 1'b1;
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 16'h0, 16'h0);
        tick();
        checkOutput("post_rst_valid", 64'(validOut), 64'(1));
        checkOutput("post_rst_z", 64'(zOut), 64'(32'h55));
        checkOutput("post_rst_count", 64'(countOut), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
